// File: rtl/flight_controller.sv
// Game sequencer for the flappy-box datapath: frame pacing, flap timing,
// collision detection, scoring and the IDLE/RUN/HIT/OVER game flow.
module flight_controller #(
  parameter logic [19:0] FRAME_DIV   = 20'd833333,
  parameter int unsigned FLAP_FRAMES = 3,
  parameter int unsigned HIT_FRAMES  = 30,
  parameter logic [6:0]  CEIL_Y      = 7'd0,
  parameter logic [6:0]  FLOOR_Y     = 7'd119,
  parameter logic [7:0]  BOX_X       = 8'd20,
  parameter logic [7:0]  BOX_W       = 8'd4,
  parameter logic [7:0]  PIPE_W      = 8'd10,
  parameter logic [7:0]  GAP_H       = 8'd30,
  parameter logic [7:0]  SCORE_X     = 8'd9
) (
  input  logic       game_clk,
  input  logic       resetn,
  input  logic       key,
  input  logic [6:0] box_y,
  input  logic [7:0] pipe_x,
  input  logic [6:0] gap_top,
  output logic       box_step,
  output logic       flap,
  output logic       box_reset,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_e;

  localparam logic [19:0] FRAME_LAST = FRAME_DIV - 20'd1;
  localparam logic [7:0]  FLAP_LOAD  = 8'(FLAP_FRAMES);
  localparam logic [7:0]  HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [8:0]  BOX_RIGHT  = {1'b0, BOX_X} + {1'b0, BOX_W} - 9'd1;
  localparam logic [8:0]  BOX_SPAN   = {1'b0, BOX_W} - 9'd1;
  localparam logic [8:0]  PIPE_SPAN  = {1'b0, PIPE_W} - 9'd1;
  localparam logic [8:0]  GAP_SPAN   = {1'b0, GAP_H} - 9'd1;

  state_e      state_q, state_d;
  logic [19:0] frame_q, frame_d;
  logic [7:0]  flap_cnt_q, flap_cnt_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  best_q, best_d;
  logic        box_step_q, box_step_d;
  logic        flap_q, flap_d;
  logic        box_reset_q, box_reset_d;

  logic key_meta_q, key_sync_q, key_prev_q, kpress_q;

  logic       tick;
  logic       collide;
  logic       hit_ceil, hit_floor, pipe_overlap, out_of_gap;
  logic [8:0] y9, px9, gt9;

  // Two-flop synchronizer followed by a registered rising-edge detector.
  always_ff @(posedge game_clk or negedge resetn) begin
    if (!resetn) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_prev_q <= 1'b0;
      kpress_q   <= 1'b0;
    end else begin
      key_meta_q <= key;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      kpress_q   <= key_sync_q & ~key_prev_q;
    end
  end

  assign y9  = {2'b00, box_y};
  assign px9 = {1'b0, pipe_x};
  assign gt9 = {2'b00, gap_top};

  assign hit_ceil     = (y9 <= {2'b00, CEIL_Y});
  assign hit_floor    = (y9 >= {2'b00, FLOOR_Y});
  assign pipe_overlap = (px9 <= BOX_RIGHT) && ((px9 + PIPE_SPAN) >= {1'b0, BOX_X});
  assign out_of_gap   = (y9 < gt9) || ((y9 + BOX_SPAN) > (gt9 + GAP_SPAN));
  assign collide      = hit_ceil || hit_floor || (pipe_overlap && out_of_gap);

  assign tick = ((state_q == RUN) || (state_q == HIT)) && (frame_q == FRAME_LAST);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    flap_cnt_d = flap_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    score_d    = score_q;
    best_d     = best_q;
    box_step_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (kpress_q) begin
          state_d    = RUN;
          score_d    = 8'd0;
          flap_cnt_d = FLAP_LOAD;
        end
      end
      RUN: begin
        if (tick && collide) begin
          state_d    = HIT;
          flap_cnt_d = 8'd0;
          if (score_q > best_q) best_d = score_q;
        end else begin
          if (tick) begin
            box_step_d = 1'b1;
            if ((pipe_x == SCORE_X) && (score_q != 8'hFF)) score_d = score_q + 8'd1;
          end
          // A press always wins over the per-frame decrement, even on a tick.
          if (kpress_q)
            flap_cnt_d = FLAP_LOAD;
          else if (tick && (flap_cnt_q != 8'd0))
            flap_cnt_d = flap_cnt_q - 8'd1;
        end
      end
      HIT: begin
        if (tick) begin
          if (hit_cnt_q == HIT_LAST)
            state_d = OVER;
          else
            hit_cnt_d = hit_cnt_q + 8'd1;
        end
      end
      OVER: begin
        if (kpress_q) begin
          state_d    = RUN;
          score_d    = 8'd0;
          flap_cnt_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      frame_d   = 20'd0;
      hit_cnt_d = 8'd0;
    end else if (tick || ((state_q != RUN) && (state_q != HIT))) begin
      frame_d = 20'd0;
    end else begin
      frame_d = frame_q + 20'd1;
    end

    flap_d      = (state_d == RUN) && (flap_cnt_d != 8'd0);
    box_reset_d = (state_d != RUN);
  end

  always_ff @(posedge game_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      frame_q     <= 20'd0;
      flap_cnt_q  <= 8'd0;
      hit_cnt_q   <= 8'd0;
      score_q     <= 8'd0;
      best_q      <= 8'd0;
      box_step_q  <= 1'b0;
      flap_q      <= 1'b0;
      box_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      flap_cnt_q  <= flap_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      score_q     <= score_d;
      best_q      <= best_d;
      box_step_q  <= box_step_d;
      flap_q      <= flap_d;
      box_reset_q <= box_reset_d;
    end
  end

  assign box_step  = box_step_q;
  assign flap      = flap_q;
  assign box_reset = box_reset_q;
  assign score     = score_q;
  assign best      = best_q;
  assign state     = state_q;

endmodule
